// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: two-requester round-robin front end for a multi-cycle FP adder
// Optional busy-cycle counter enabled by defining FP_ADD_ARB_BUSY_CNT_EN.
module fp_add_arbiter #(
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_sum,
    output logic        resp_err,
    output logic        add_en,
    output logic        add_load,
    output logic        add_plus_or_minus,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        add_ready,
    output logic [15:0] busy_cycles
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t        state;
    logic          last;
    logic [CW-1:0] cnt;

    // grant goes to the requester not served last when both are valid
    always_comb begin
        req0_ready = state == IDLE && req0_valid && (!req1_valid || last);
        req1_ready = state == IDLE && req1_valid && (!req0_valid || !last);
    end

    // request/response sequencing with all adder and response outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            last              <= 1'b1;
            cnt               <= '0;
            resp_valid        <= 1'b0;
            resp_err          <= 1'b0;
            resp_sum          <= '0;
            resp_id           <= 1'b0;
            add_en            <= 1'b0;
            add_load          <= 1'b0;
            add_plus_or_minus <= 1'b0;
            add_a             <= '0;
            add_b             <= '0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    add_a             <= req0_ready ? req0_a : req1_a;
                    add_b             <= req0_ready ? req0_b : req1_b;
                    add_plus_or_minus <= req0_ready ? req0_op : req1_op;
                    resp_id           <= req1_ready;
                    last              <= req1_ready;
                    add_load          <= 1'b1;
                    add_en            <= 1'b1;
                    state             <= LOAD;
                end
                LOAD: begin
                    add_load <= 1'b0;
                    cnt      <= CW'(1);
                    state    <= WAIT;
                end
                WAIT: if ((cnt >= CW'(MIN_WAIT) && add_ready) || cnt >= CW'(TIMEOUT)) begin
                    resp_sum   <= (cnt >= CW'(MIN_WAIT) && add_ready) ? add_sum : 32'h0;
                    resp_err   <= !(cnt >= CW'(MIN_WAIT) && add_ready);
                    resp_valid <= 1'b1;
                    add_en     <= 1'b0;
                    cnt        <= '0;
                    state      <= RESP;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP_ADD_ARB_BUSY_CNT_EN
    // saturating count of every non-IDLE cycle, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_cycles <= '0;
        else if (state != IDLE && busy_cycles != 16'hFFFF)
            busy_cycles <= busy_cycles + 16'd1;
    end
`else
    assign busy_cycles = '0;
`endif
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: transaction-level model plus directed scenarios for fp_add_arbiter
module tb_fp_add_arbiter;
    localparam int MW = 2;
    localparam int TO = 16;
`ifdef FP_ADD_ARB_BUSY_CNT_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_sum;
    logic        add_en, add_load, add_plus_or_minus, add_ready;
    logic [31:0] add_a, add_b, add_sum;
    logic [15:0] busy_cycles;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] stub_sum;
    int          stub_delay;
    int          load_c = 0;
    bit          loaded = 1'b0;

    bit          busy_m = 1'b0;
    bit          last_m = 1'b1;
    int          t_acc, k_m, bc_m, acc_cyc;
    logic        id_m, err_m, op_m;
    logic [31:0] sum_m, a_m, b_m;
    int          grants[$];

    fp_add_arbiter #(.MIN_WAIT(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_sum(resp_sum), .resp_err(resp_err),
        .add_en(add_en), .add_load(add_load), .add_plus_or_minus(add_plus_or_minus),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_ready(add_ready),
        .busy_cycles(busy_cycles)
    );

    assign add_sum = stub_sum;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // adder stub: add_ready rises stub_delay cycles after the load pulse and stays high
    initial begin
        add_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (add_load) begin
                load_c = cyc;
                loaded = 1'b1;
            end
            add_ready = loaded && (cyc >= load_c + stub_delay);
        end
    end

    // transaction model: each accepted op finishes k cycles of WAIT after its load
    initial begin
        int   rel;
        logic e0, e1;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_err", resp_err, 0);
                chk("rst_resp_sum", resp_sum, 0);
                chk("rst_resp_id", resp_id, 0);
                chk("rst_add_en", add_en, 0);
                chk("rst_add_load", add_load, 0);
                chk("rst_add_a", add_a, 0);
                chk("rst_add_b", add_b, 0);
                chk("rst_add_pm", add_plus_or_minus, 0);
                chk("rst_busy", {16'h0, busy_cycles}, 0);
                busy_m = 1'b0;
                last_m = 1'b1;
                bc_m = 0;
                a_m = 0;
                b_m = 0;
                op_m = 0;
            end else begin
                e0 = !busy_m && req0_valid && (!req1_valid || last_m);
                e1 = !busy_m && req1_valid && (!req0_valid || !last_m);
                chk("req0_ready", req0_ready, e0);
                chk("req1_ready", req1_ready, e1);
                rel = cyc - t_acc;
                chk("add_load", add_load, busy_m && rel == 1);
                chk("add_en", add_en, busy_m && rel >= 1 && rel < k_m + 2);
                chk("resp_valid", resp_valid, busy_m && rel >= k_m + 2);
                if (busy_m && rel >= k_m + 2) begin
                    chk("resp_id", resp_id, id_m);
                    chk("resp_sum", resp_sum, sum_m);
                    chk("resp_err", resp_err, err_m);
                end
                chk("add_a", add_a, a_m);
                chk("add_b", add_b, b_m);
                chk("add_pm", add_plus_or_minus, op_m);
                chk("busy_cycles", {16'h0, busy_cycles}, BC ? 32'(bc_m) : 32'h0);
                if (busy_m && rel >= 1 && bc_m < 65535) bc_m++;
                if (busy_m && rel >= k_m + 2 && resp_ready) begin
                    busy_m = 1'b0;
                end else if (e0 || e1) begin
                    busy_m = 1'b1;
                    t_acc = cyc;
                    acc_cyc = cyc;
                    id_m = e1;
                    last_m = e1;
                    a_m = e0 ? req0_a : req1_a;
                    b_m = e0 ? req0_b : req1_b;
                    op_m = e0 ? req0_op : req1_op;
                    err_m = stub_delay > TO;
                    k_m = err_m ? TO : (stub_delay < MW ? MW : stub_delay);
                    sum_m = err_m ? 32'h0 : stub_sum;
                    grants.push_back(e1 ? 1 : 0);
                end
            end
        end
    end

    task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b, input logic op);
        int i;
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n == 0 ? req0_ready : req1_ready) break;
        end
        chk("grant_wait", i < 100, 1);
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_rv(input logic id, input logic [31:0] sum, input logic err, input int lat);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        chk("rv_wait", i < 100, 1);
        chk("lit_latency", cyc - acc_cyc, lat);
        chk("lit_id", resp_id, id);
        chk("lit_sum", resp_sum, sum);
        chk("lit_err", resp_err, err);
    endtask

    task automatic finish_resp();
        int i;
        for (i = 0; i < 100; i++) begin
            if (resp_valid && resp_ready) break;
            @(negedge clk);
        end
        chk("resp_done_wait", i < 100, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0;
        int i;
        int pat[4] = '{0, 1, 0, 1};
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        resp_ready = 1'b1;
        stub_delay = 2;
        stub_sum = 32'h411C0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 32'h01580000, 32'h00C00000, 1'b0);
        wait_rv(1'b0, 32'h411C0000, 1'b0, 4);
        chk("s1_add_a", add_a, 32'h01580000);
        chk("s1_add_b", add_b, 32'h00C00000);
        finish_resp();

        do_reset();
        stub_sum = 32'h40400000;
        req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = 1'b0;
        req1_a = 32'h40800000; req1_b = 32'h3F000000; req1_op = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        g0 = grants.size();
        for (i = 0; i < 200 && grants.size() < g0 + 4; i++) @(negedge clk);
        chk("s2_grant_wait", i < 200, 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int j = 0; j < 4; j++)
            chk("s2_grant_order", (grants.size() > g0 + j) ? grants[g0 + j] : -1, pat[j]);
        for (i = 0; i < 100 && busy_m; i++) @(negedge clk);
        chk("s2_idle_wait", i < 100, 1);
        @(posedge clk);
        #1;

        stub_delay = 1000;
        issue(1, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        wait_rv(1'b1, 32'h0, 1'b1, 18);
        finish_resp();

        stub_delay = 3;
        stub_sum = 32'hC0A00000;
        resp_ready = 1'b0;
        issue(0, 32'h40A00000, 32'h41200000, 1'b1);
        wait_rv(1'b0, 32'hC0A00000, 1'b0, 5);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) begin
                req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_op = 1'b0; req1_valid = 1'b1;
            end
            @(negedge clk);
            chk("s4_hold_valid", resp_valid, 1);
            chk("s4_hold_sum", resp_sum, 32'hC0A00000);
            chk("s4_hold_id", resp_id, 0);
            chk("s4_no_ready0", req0_ready, 0);
            chk("s4_no_ready1", req1_ready, 0);
            chk("s4_no_load", add_load, 0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        issue(1, 32'h3F800000, 32'h3F800000, 1'b0);
        wait_rv(1'b1, 32'hC0A00000, 1'b0, 5);
        finish_resp();

        stub_delay = 2;
        stub_sum = 32'h40E00000;
        issue(0, 32'h40400000, 32'h40800000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("s5_async_en", add_en, 0);
        chk("s5_async_a", add_a, 0);
        chk("s5_async_b", add_b, 0);
        chk("s5_async_valid", resp_valid, 0);
        chk("s5_async_busy", {16'h0, busy_cycles}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        req0_a = 32'h41000000; req0_b = 32'h3F800000; req0_op = 1'b0; req0_valid = 1'b1;
        req1_a = 32'h41100000; req1_b = 32'h3F800000; req1_op = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("s5_tie_ready0", req0_ready, 1);
        chk("s5_tie_ready1", req1_ready, 0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rv(1'b0, 32'h40E00000, 1'b0, 4);
        finish_resp();
        @(negedge clk);
        chk("s6_busy_cycles", {16'h0, busy_cycles}, BC ? 32'd4 : 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
